// File: rtl/mem_download_gen_if.sv
// Purpose : flit-in / message-out bundle between the memory FIFO, mem_download_gen and the memory controller.
// Latency : n/a (wires only); the slave modport is the deserializer, the master modport is its surroundings.
// Backpres: m_download_ready low means the FIFO must hold its flit; mem_done_access releases a message.
interface mem_download_gen_if #(
   parameter int FLIT_W    = 16,
   parameter int MAX_FLITS = 11
);
   localparam int MSG_W = FLIT_W * MAX_FLITS;
   localparam int CNT_W = $clog2(MAX_FLITS + 1);

   logic [FLIT_W-1:0] IN_flit_mem;
   logic              v_IN_flit_mem;
   logic [1:0]        In_flit_ctrl;
   logic              mem_done_access;
   logic              m_download_ready;
   logic              v_m_download;
   logic [MSG_W-1:0]  m_download_flits;
   logic [CNT_W-1:0]  m_download_flit_cnt;
   logic [1:0]        m_download_state;
   logic              m_download_err;

   // the deserializer itself
   modport slave (
      input  IN_flit_mem, v_IN_flit_mem, In_flit_ctrl, mem_done_access,
      output m_download_ready, v_m_download, m_download_flits,
             m_download_flit_cnt, m_download_state, m_download_err
   );

   // FIFO + memory controller side
   modport master (
      output IN_flit_mem, v_IN_flit_mem, In_flit_ctrl, mem_done_access,
      input  m_download_ready, v_m_download, m_download_flits,
             m_download_flit_cnt, m_download_state, m_download_err
   );
endinterface

// File: rtl/mem_download_gen.sv
// Purpose : packs 1..MAX_FLITS flits (head at MSBs) into one message and holds it for the memory controller.
// Latency : message valid from the edge that accepts the tail; released on the edge mem_done_access is seen.
// Backpres: ready is low only while a message is presented (RDY); one bubble cycle per message after release.
// Ports   : clk, rst (async active-low), bus (slave modport: flit in, message/count/state/err out).
module mem_download_gen #(
   parameter int FLIT_W    = 16,
   parameter int MAX_FLITS = 11
) (
   input  logic              clk,
   input  logic              rst,
   mem_download_gen_if.slave bus
);
   localparam int MSG_W = FLIT_W * MAX_FLITS;
   localparam int CNT_W = $clog2(MAX_FLITS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_FLITS);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   localparam logic [1:0] CTRL_NONE = 2'b00;
   localparam logic [1:0] CTRL_HEAD = 2'b01;
   localparam logic [1:0] CTRL_TAIL = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      RDY  = 2'b10
   } state_t;

   state_t           state;
   logic [MSG_W-1:0] msg;
   logic [CNT_W-1:0] cnt;
   logic             msg_vld;
   logic             err;
   // Set after an overflow: non-head flits keep being dropped (with err)
   // until a head resynchronises us, so a stray tail is not mistaken for
   // a single-flit message.
   logic             drop;

   logic             accept;
   logic [MSG_W-1:0] head_msg;
   logic [MSG_W-1:0] slot_msg;

   assign accept = bus.v_IN_flit_mem && (state != RDY) && (bus.In_flit_ctrl != CTRL_NONE);

   always_comb begin
      // fresh buffer with the flit in slot 0
      head_msg = '0;
      head_msg[MSG_W-1 -: FLIT_W] = bus.IN_flit_mem;
      // current buffer with the flit in slot cnt
      slot_msg = msg;
      for (int i = 0; i < MAX_FLITS; i++) begin
         if (cnt == CNT_W'(i)) begin
            slot_msg[MSG_W-1-i*FLIT_W -: FLIT_W] = bus.IN_flit_mem;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         msg     <= '0;
         cnt     <= '0;
         msg_vld <= 1'b0;
         err     <= 1'b0;
         drop    <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (bus.In_flit_ctrl == CTRL_HEAD) begin
                     msg  <= head_msg;
                     cnt  <= CNT_ONE;
                     drop <= 1'b0;
                     if (MAX_FLITS == 1) begin
                        state   <= RDY;
                        msg_vld <= 1'b1;
                     end else begin
                        state <= BUSY;
                     end
                  end else if (bus.In_flit_ctrl == CTRL_TAIL && !drop) begin
                     msg     <= head_msg;
                     cnt     <= CNT_ONE;
                     state   <= RDY;
                     msg_vld <= 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            BUSY: begin
               if (accept) begin
                  if (bus.In_flit_ctrl == CTRL_HEAD) begin
                     // unexpected head: abandon the partial message, restart
                     msg <= head_msg;
                     cnt <= CNT_ONE;
                     err <= 1'b1;
                  end else if (cnt < CNT_MAX) begin
                     msg <= slot_msg;
                     cnt <= cnt + CNT_ONE;
                     if (bus.In_flit_ctrl == CTRL_TAIL) begin
                        state   <= RDY;
                        msg_vld <= 1'b1;
                     end
                  end else begin
                     // overflow
                     err   <= 1'b1;
                     cnt   <= '0;
                     drop  <= 1'b1;
                     state <= IDLE;
                  end
               end
            end
            RDY: begin
               if (bus.mem_done_access) begin
                  state   <= IDLE;
                  msg_vld <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               msg_vld <= 1'b0;
            end
         endcase
      end
   end

   assign bus.m_download_ready    = (state != RDY);
   assign bus.v_m_download        = msg_vld;
   assign bus.m_download_flits    = msg;
   assign bus.m_download_flit_cnt = cnt;
   assign bus.m_download_state    = state;
   assign bus.m_download_err      = err;
endmodule

// File: tb/tb_mem_download_gen.sv
module tb_mem_download_gen;
   logic clk;
   logic rst_a;
   logic rst_b;
   int   total;
   int   bad;

   typedef struct {
      logic [175:0] flits;
      logic [3:0]   cnt;
   } exp_a_t;
   typedef struct {
      logic [31:0] flits;
      logic [2:0]  cnt;
   } exp_b_t;

   exp_a_t q_a[$];
   exp_b_t q_b[$];

   mem_download_gen_if #(.FLIT_W(16), .MAX_FLITS(11)) a ();
   mem_download_gen_if #(.FLIT_W(8),  .MAX_FLITS(4))  b ();

   mem_download_gen #(.FLIT_W(16), .MAX_FLITS(11)) dut_a (.clk(clk), .rst(rst_a), .bus(a.slave));
   mem_download_gen #(.FLIT_W(8),  .MAX_FLITS(4))  dut_b (.clk(clk), .rst(rst_b), .bus(b.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // one cycle on DUT A: present inputs, take the edge, sample 1 time unit later
   task automatic drive_a(input logic v, input logic [1:0] ctrl, input logic [15:0] d);
      a.v_IN_flit_mem = v;
      a.In_flit_ctrl  = ctrl;
      a.IN_flit_mem   = d;
      @(posedge clk);
      #1;
      a.v_IN_flit_mem = 1'b0;
      a.In_flit_ctrl  = 2'b00;
   endtask

   task automatic drive_b(input logic v, input logic [1:0] ctrl, input logic [7:0] d);
      b.v_IN_flit_mem = v;
      b.In_flit_ctrl  = ctrl;
      b.IN_flit_mem   = d;
      @(posedge clk);
      #1;
      b.v_IN_flit_mem = 1'b0;
      b.In_flit_ctrl  = 2'b00;
   endtask

   task automatic done_a();
      a.mem_done_access = 1'b1;
      @(posedge clk);
      #1;
      a.mem_done_access = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      total++; if (a.m_download_state !== 2'b00) begin bad++; $display("FAIL reset_state got=%0h exp=0", a.m_download_state); end
      total++; if (a.v_m_download !== 1'b0) begin bad++; $display("FAIL reset_v got=%0b exp=0", a.v_m_download); end
      total++; if (a.m_download_flits !== 176'h0) begin bad++; $display("FAIL reset_flits got=%0h exp=0", a.m_download_flits); end
      total++; if (a.m_download_flit_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", a.m_download_flit_cnt); end
      total++; if (a.m_download_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", a.m_download_err); end
      total++; if (a.m_download_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", a.m_download_ready); end
      // a head offered while reset is held must not be taken
      drive_a(1'b1, 2'b01, 16'hDEAD);
      total++; if (a.m_download_flit_cnt !== 4'd0 || a.m_download_state !== 2'b00) begin
         bad++; $display("FAIL reset_no_accept cnt=%0d state=%0h exp cnt=0 state=0", a.m_download_flit_cnt, a.m_download_state);
      end
      rst_a = 1'b1;
      drive_a(1'b0, 2'b00, 16'h0);
   endtask

   task automatic test_long_msg();
      exp_a_t e;
      logic   v_early;
      logic [1:0] seq_ctrl [13];
      logic       seq_v    [13];
      e.flits = '0;
      for (int i = 0; i < 11; i++) e.flits[175-16*i -: 16] = 16'h1234;
      e.cnt = 4'd11;
      // head, 4 body, gap, 3 body, gap, 2 body, tail
      for (int i = 0; i < 13; i++) begin seq_ctrl[i] = 2'b10; seq_v[i] = 1'b1; end
      seq_ctrl[0] = 2'b01; seq_ctrl[12] = 2'b11;
      seq_v[5] = 1'b0; seq_v[9] = 1'b0;
      v_early = 1'b0;
      for (int i = 0; i < 13; i++) begin
         if (i == 12) q_a.push_back(e);
         drive_a(seq_v[i], seq_ctrl[i], 16'h1234);
         if (i < 12 && a.v_m_download !== 1'b0) v_early = 1'b1;
      end
      total++; if (v_early !== 1'b0) begin bad++; $display("FAIL long_v_before_tail got=1 exp=0"); end
      total++; if (a.v_m_download !== 1'b1) begin bad++; $display("FAIL long_v got=%0b exp=1", a.v_m_download); end
      total++; if (a.m_download_state !== 2'b10) begin bad++; $display("FAIL long_state got=%0h exp=2", a.m_download_state); end
      total++; if (q_a.size() == 0) begin bad++; $display("FAIL long_sb scoreboard empty"); end
      else begin
         e = q_a.pop_front();
         total++; if (a.m_download_flits !== e.flits) begin bad++; $display("FAIL long_flits got=%0h exp=%0h", a.m_download_flits, e.flits); end
         total++; if (a.m_download_flit_cnt !== e.cnt) begin bad++; $display("FAIL long_cnt got=%0d exp=%0d", a.m_download_flit_cnt, e.cnt); end
      end
      done_a();
   endtask

   task automatic test_short_msg();
      exp_a_t e;
      e.flits = {16'hA001, 16'hA002, 16'hA003, 128'h0};
      e.cnt   = 4'd3;
      drive_a(1'b1, 2'b01, 16'hA001);
      drive_a(1'b0, 2'b10, 16'hFFFF);
      drive_a(1'b1, 2'b10, 16'hA002);
      q_a.push_back(e);
      drive_a(1'b1, 2'b11, 16'hA003);
      total++; if (q_a.size() == 0) begin bad++; $display("FAIL short_sb scoreboard empty"); end
      else begin
         e = q_a.pop_front();
         total++; if (a.m_download_flits !== e.flits) begin bad++; $display("FAIL short_flits got=%0h exp=%0h", a.m_download_flits, e.flits); end
         total++; if (a.m_download_flit_cnt !== e.cnt) begin bad++; $display("FAIL short_cnt got=%0d exp=%0d", a.m_download_flit_cnt, e.cnt); end
      end
      done_a();
      total++; if (a.m_download_state !== 2'b00 || a.m_download_ready !== 1'b1 || a.v_m_download !== 1'b0) begin
         bad++; $display("FAIL short_release state=%0h ready=%0b v=%0b exp 0/1/0", a.m_download_state, a.m_download_ready, a.v_m_download);
      end
   endtask

   task automatic test_single_tail();
      exp_a_t e;
      e.flits = {16'hBEEF, 160'h0};
      e.cnt   = 4'd1;
      q_a.push_back(e);
      drive_a(1'b1, 2'b11, 16'hBEEF);
      total++; if (a.v_m_download !== 1'b1) begin bad++; $display("FAIL tail_v got=%0b exp=1", a.v_m_download); end
      total++; if (q_a.size() == 0) begin bad++; $display("FAIL tail_sb scoreboard empty"); end
      else begin
         e = q_a.pop_front();
         total++; if (a.m_download_flits !== e.flits) begin bad++; $display("FAIL tail_flits got=%0h exp=%0h", a.m_download_flits, e.flits); end
         total++; if (a.m_download_flit_cnt !== e.cnt) begin bad++; $display("FAIL tail_cnt got=%0d exp=%0d", a.m_download_flit_cnt, e.cnt); end
      end
      // flits offered while RDY must be refused
      for (int i = 0; i < 2; i++) begin
         total++; if (a.m_download_ready !== 1'b0) begin bad++; $display("FAIL rdy_ready got=%0b exp=0", a.m_download_ready); end
         drive_a(1'b1, 2'b10, 16'h5555);
         total++; if (a.m_download_flit_cnt !== 4'd1 || a.m_download_flits !== e.flits) begin
            bad++; $display("FAIL rdy_hold cnt=%0d flits=%0h exp cnt=1 flits=%0h", a.m_download_flit_cnt, a.m_download_flits, e.flits);
         end
      end
      done_a();
   endtask

   task automatic test_overflow();
      logic v_seen;
      v_seen = 1'b0;
      drive_a(1'b1, 2'b01, 16'h0100);
      for (int i = 1; i <= 10; i++) begin
         drive_a(1'b1, 2'b10, 16'(16'h0100 + i));
         if (a.v_m_download !== 1'b0) v_seen = 1'b1;
      end
      total++; if (a.m_download_err !== 1'b0) begin bad++; $display("FAIL ovf_err_early got=%0b exp=0", a.m_download_err); end
      drive_a(1'b1, 2'b10, 16'h01FF);
      total++; if (a.m_download_err !== 1'b1) begin bad++; $display("FAIL ovf_err got=%0b exp=1", a.m_download_err); end
      total++; if (a.m_download_state !== 2'b00) begin bad++; $display("FAIL ovf_state got=%0h exp=0", a.m_download_state); end
      drive_a(1'b0, 2'b00, 16'h0);
      total++; if (a.m_download_err !== 1'b0) begin bad++; $display("FAIL ovf_err_pulse got=%0b exp=0", a.m_download_err); end
      drive_a(1'b1, 2'b11, 16'h02FF);
      if (a.v_m_download !== 1'b0) v_seen = 1'b1;
      total++; if (a.m_download_err !== 1'b1) begin bad++; $display("FAIL ovf_tail_err got=%0b exp=1", a.m_download_err); end
      total++; if (a.m_download_state !== 2'b00) begin bad++; $display("FAIL ovf_tail_state got=%0h exp=0", a.m_download_state); end
      total++; if (v_seen !== 1'b0) begin bad++; $display("FAIL ovf_v got=1 exp=0"); end
      drive_a(1'b0, 2'b00, 16'h0);
   endtask

   task automatic test_head_restart();
      exp_a_t e;
      e.flits = {16'h2222, 16'h3333, 144'h0};
      e.cnt   = 4'd2;
      drive_a(1'b1, 2'b01, 16'h1111);
      drive_a(1'b1, 2'b10, 16'h1112);
      drive_a(1'b1, 2'b01, 16'h2222);
      total++; if (a.m_download_err !== 1'b1) begin bad++; $display("FAIL restart_err got=%0b exp=1", a.m_download_err); end
      total++; if (a.m_download_flit_cnt !== 4'd1) begin bad++; $display("FAIL restart_cnt got=%0d exp=1", a.m_download_flit_cnt); end
      total++; if (a.m_download_flits !== {16'h2222, 160'h0}) begin bad++; $display("FAIL restart_flits got=%0h exp=2222 then zeros", a.m_download_flits); end
      total++; if (a.m_download_state !== 2'b01) begin bad++; $display("FAIL restart_state got=%0h exp=1", a.m_download_state); end
      q_a.push_back(e);
      drive_a(1'b1, 2'b11, 16'h3333);
      total++; if (a.m_download_err !== 1'b0) begin bad++; $display("FAIL restart_tail_err got=%0b exp=0", a.m_download_err); end
      total++; if (q_a.size() == 0) begin bad++; $display("FAIL restart_sb scoreboard empty"); end
      else begin
         e = q_a.pop_front();
         total++; if (a.m_download_flits !== e.flits) begin bad++; $display("FAIL restart_msg got=%0h exp=%0h", a.m_download_flits, e.flits); end
         total++; if (a.m_download_flit_cnt !== e.cnt) begin bad++; $display("FAIL restart_msg_cnt got=%0d exp=%0d", a.m_download_flit_cnt, e.cnt); end
      end
      done_a();
   endtask

   task automatic test_back_to_back();
      a.mem_done_access = 1'b1;
      // mem_done_access must not disturb a message being built
      drive_a(1'b1, 2'b01, 16'h7001);
      total++; if (a.m_download_state !== 2'b01) begin bad++; $display("FAIL b2b_busy got=%0h exp=1", a.m_download_state); end
      drive_a(1'b1, 2'b11, 16'h7002);
      a.mem_done_access = 1'b1;
      total++; if (a.v_m_download !== 1'b1 || a.m_download_flit_cnt !== 4'd2) begin
         bad++; $display("FAIL b2b_v v=%0b cnt=%0d exp v=1 cnt=2", a.v_m_download, a.m_download_flit_cnt);
      end
      drive_a(1'b0, 2'b00, 16'h0);
      a.mem_done_access = 1'b1;
      total++; if (a.v_m_download !== 1'b0 || a.m_download_state !== 2'b00) begin
         bad++; $display("FAIL b2b_release v=%0b state=%0h exp v=0 state=0", a.v_m_download, a.m_download_state);
      end
      // registers keep the last message after release
      total++; if (a.m_download_flits !== {16'h7001, 16'h7002, 144'h0}) begin bad++; $display("FAIL b2b_keep got=%0h", a.m_download_flits); end
      a.mem_done_access = 1'b0;
   endtask

   task automatic test_param_b();
      exp_b_t e;
      e.flits = 32'h01020304;
      e.cnt   = 3'd4;
      rst_b = 1'b1;
      drive_b(1'b0, 2'b00, 8'h0);
      drive_b(1'b1, 2'b01, 8'h01);
      drive_b(1'b1, 2'b10, 8'h02);
      drive_b(1'b1, 2'b10, 8'h03);
      q_b.push_back(e);
      drive_b(1'b1, 2'b11, 8'h04);
      total++; if (q_b.size() == 0) begin bad++; $display("FAIL b_sb scoreboard empty"); end
      else begin
         e = q_b.pop_front();
         total++; if (b.m_download_flits !== e.flits) begin bad++; $display("FAIL b_flits got=%0h exp=%0h", b.m_download_flits, e.flits); end
         total++; if (b.m_download_flit_cnt !== e.cnt || b.v_m_download !== 1'b1) begin
            bad++; $display("FAIL b_cnt cnt=%0d v=%0b exp cnt=%0d v=1", b.m_download_flit_cnt, b.v_m_download, e.cnt);
         end
      end
      b.mem_done_access = 1'b1;
      drive_b(1'b0, 2'b00, 8'h0);
      b.mem_done_access = 1'b0;
      drive_b(1'b1, 2'b01, 8'h0A);
      drive_b(1'b1, 2'b10, 8'h0B);
      drive_b(1'b1, 2'b01, 8'h0C);
      total++; if (b.m_download_err !== 1'b1) begin bad++; $display("FAIL b_pre_rst_err got=%0b exp=1", b.m_download_err); end
      // reset mid-message, away from any clock edge
      rst_b = 1'b0;
      #1;
      total++; if (b.m_download_state !== 2'b00 || b.v_m_download !== 1'b0 || b.m_download_flits !== 32'h0 ||
                   b.m_download_flit_cnt !== 3'd0 || b.m_download_err !== 1'b0 || b.m_download_ready !== 1'b1) begin
         bad++; $display("FAIL b_async_rst state=%0h v=%0b flits=%0h cnt=%0d err=%0b ready=%0b exp 0/0/0/0/0/1",
                         b.m_download_state, b.v_m_download, b.m_download_flits, b.m_download_flit_cnt,
                         b.m_download_err, b.m_download_ready);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_a = 1'b1;
      rst_b = 1'b1;
      a.IN_flit_mem = '0; a.v_IN_flit_mem = 1'b0; a.In_flit_ctrl = 2'b00; a.mem_done_access = 1'b0;
      b.IN_flit_mem = '0; b.v_IN_flit_mem = 1'b0; b.In_flit_ctrl = 2'b00; b.mem_done_access = 1'b0;
      #1;
      rst_a = 1'b0;
      rst_b = 1'b0;
      test_reset();
      test_long_msg();
      test_short_msg();
      test_single_tail();
      test_overflow();
      test_head_restart();
      test_back_to_back();
      test_param_b();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_download_gen.md
# mem_download_gen

Parametrised successor to the memory-side flit deserializer. It collects FLIT_W-bit flits from the memory input FIFO into one message of 1..MAX_FLITS flits, then presents the message and its flit count to the memory controller, holding it until the controller signals completion. It adds three things the fixed-width generation lacks: variable message length, an explicit upstream ready, and protocol-error reporting.

## Interface
- FLIT_W, 16, flit width in bits
- MAX_FLITS, 11, maximum flits per message (≥1)
- MSG_W, FLIT_W*MAX_FLITS, derived; do not override
- CNT_W, $clog2(MAX_FLITS+1), derived; do not override

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- IN_flit_mem  in  FLIT_W  incoming flit
- v_IN_flit_mem  in  1  flit valid
- In_flit_ctrl  in  2  flit type: 00 none, 01 head, 10 body, 11 tail (a tail while IDLE is a single-flit message)
- mem_done_access  in  1  memory has consumed the presented message
- m_download_ready  out  1  block accepts a flit this cycle
- v_m_download  out  1  message valid
- m_download_flits  out  MSG_W  assembled message, head flit at the MSBs
- m_download_flit_cnt  out  CNT_W  number of flits in the message
- m_download_state  out  2  00 IDLE, 01 BUSY, 10 RDY
- m_download_err  out  1  one-cycle protocol-error pulse

## Operation
- A flit is accepted at a rising edge when v_IN_flit_mem=1, m_download_ready=1 and In_flit_ctrl≠00. If v=1 and ctrl=00, the flit is ignored and no error is raised.
- m_download_ready = (state≠RDY). The upstream FIFO must hold its flit while ready=0.
- Packing: the i-th flit (0-based) goes to bits [MSG_W-1-i*FLIT_W -: FLIT_W]. Unfilled low slots read zero. Accepting a head clears the whole buffer before the head is written.
- IDLE:
  - head → buffer cleared, slot 0 written, cnt=1, go to BUSY.
  - tail → buffer cleared, slot 0 written, cnt=1, go to RDY.
  - body → flit dropped, err pulse, stay IDLE.
- BUSY:
  - body with cnt<MAX_FLITS → write slot cnt, cnt+1.
  - tail with cnt<MAX_FLITS → write slot cnt, cnt+1, go to RDY.
  - head → current message discarded, err pulse, restart exactly as a head from IDLE (cnt=1, stay BUSY).
  - body or tail with cnt==MAX_FLITS → overflow: message discarded, err pulse, cnt=0, go to IDLE. Later non-head flits are dropped with an err pulse each, per the IDLE rules.
- RDY:
  - v_m_download=1; flits and cnt are held stable.
  - mem_done_access=1 → go to IDLE, v_m_download=0. The flits and cnt registers keep their contents until the next accepted head or tail.
  - mem_done_access is ignored in IDLE and BUSY.
- MAX_FLITS=1: a head accepted from IDLE goes directly to RDY.

## Timing
- Reset values (async on rst=0): state IDLE, v_m_download=0, m_download_flits=0, cnt=0, err=0. m_download_ready=1 while in reset, but no flit is accepted while rst=0.
- Completion latency: tail accepted at edge N → v_m_download=1 and state=10 from edge N.
- Release: mem_done_access sampled high at edge M in RDY → v=0 and ready=1 from edge M. The earliest next head is accepted at edge M+1, so there is one bubble per message.
- err asserts for exactly the cycle following the offending edge. It is registered and never combinational.
- Reset asserted mid-message or in RDY: the partial or presented message is lost and the block returns to IDLE immediately.
- mem_done_access held high continuously: each message is released one cycle after it enters RDY.

## Test plan
- Default params. Head plus 9 bodies plus tail, all 16'h1234, with two single-cycle v=0 gaps → v_m_download rises on the tail edge, cnt=11, flits = 11 repeats of 1234, state=10. Before the tail, v stays 0.
- 3-flit message 16'hA001/A002/A003 with a one-cycle gap → flits[175:128]=A001A002A003, low 128 bits zero, cnt=3. mem_done_access=1 for one cycle → state=00, ready=1 next cycle.
- Single tail 16'hBEEF while IDLE → cnt=1, flits[175:160]=BEEF, rest zero, v=1 on that edge. Flits offered during RDY are not accepted: ready=0 and the flit count does not change.
- Overflow: head plus 10 bodies plus another body → err pulse for one cycle, state=00, v never asserts. The following tail raises a second err pulse.
- Head 16'h1111, body, then head 16'h2222 → err pulse, cnt=1, flits[175:160]=2222. A subsequent tail gives cnt=2.
- Parametrised run with FLIT_W=8, MAX_FLITS=4: 4-flit message 8'h01..04 → flits=32'h01020304. Assert reset mid-message → all outputs return to reset values asynchronously.
